// File: rtl/phase_adjust_unit.sv
`default_nettype none
// ============================================================================
// Module   : phase_adjust_unit
// Purpose  : Multi-channel phase-offset stage placed between the DDS phase
//            accumulators and the phase-to-amplitude LUTs. Each channel keeps
//            a persistent offset that is added to the MSB-aligned top bits of
//            its phase word. Offset updates use a request/ack handshake and
//            take effect on a valid sample boundary, so no output sample ever
//            sees a half-applied offset.
// Ports    : i_clk, i_rst_n          - clock (rising edge), async active-low reset
//            i_phase_valid, i_phase  - incoming packed phases (ch0 in LSBs)
//            i_adj_req               - level request, acted on at its rising edge
//            i_adj_ch/val/mode       - target channel, step, 00 add / 01 sub /
//                                      10 load / 11 add
//            i_offset_clr            - only when PHASE_ADJ_CLEAR_EN is defined:
//                                      clears all offsets, aborts a pending request
//            o_phase_valid, o_phase  - corrected phases, 2-cycle latency
//            o_adj_busy, o_adj_ack   - request pending / one-cycle commit pulse
// Options  : `define PHASE_ADJ_CLEAR_EN to add the i_offset_clr port.
// Revision : 1.0 - initial release
// ============================================================================
module phase_adjust_unit #(
   parameter int P_NUM_CH      = 2,
   parameter int P_PHASE_WIDTH = 24,
   parameter int P_ADJ_WIDTH   = 12,
   localparam int C_CH_W       = (P_NUM_CH > 1) ? $clog2(P_NUM_CH) : 1
) (
   input  logic                              i_clk,
   input  logic                              i_rst_n,
`ifdef PHASE_ADJ_CLEAR_EN
   input  logic                              i_offset_clr,
`endif
   input  logic                              i_phase_valid,
   input  logic [P_NUM_CH*P_PHASE_WIDTH-1:0] i_phase,
   input  logic                              i_adj_req,
   input  logic [C_CH_W-1:0]                 i_adj_ch,
   input  logic [P_ADJ_WIDTH-1:0]            i_adj_val,
   input  logic [1:0]                        i_adj_mode,
   output logic                              o_phase_valid,
   output logic [P_NUM_CH*P_PHASE_WIDTH-1:0] o_phase,
   output logic                              o_adj_busy,
   output logic                              o_adj_ack
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ARM  = 2'd1;
   localparam logic [1:0] S_ACK  = 2'd2;

   localparam logic [1:0] C_MODE_SUB  = 2'b01;
   localparam logic [1:0] C_MODE_LOAD = 2'b10;

   logic [1:0]                        r_state;
   logic                              r_req_d;
   logic [C_CH_W-1:0]                 r_ch;
   logic [P_ADJ_WIDTH-1:0]            r_val;
   logic [1:0]                        r_mode;
   logic [P_NUM_CH*P_PHASE_WIDTH-1:0] r_s1_phase;
   logic                              r_s1_valid;
   logic [P_NUM_CH*P_PHASE_WIDTH-1:0] w_sum;
   logic                              w_clr;
   logic                              w_req_edge;
   logic                              w_commit;

`ifdef PHASE_ADJ_CLEAR_EN
   assign w_clr = i_offset_clr;
`else
   assign w_clr = 1'b0;
`endif

   assign w_req_edge = i_adj_req & ~r_req_d;
   // The commit coincides with the stage-1 sample moving into stage 2, so that
   // sample already sees the new offset. A clear in the same cycle wins.
   assign w_commit   = (r_state == S_ARM) & r_s1_valid & ~w_clr;

   assign o_adj_busy = (r_state == S_ARM);
   assign o_adj_ack  = (r_state == S_ACK);

   // ------------------------------------------------------------------------
   // Per-channel offset register and stage-2 adder
   // ------------------------------------------------------------------------
   for (genvar ch = 0; ch < P_NUM_CH; ch++) begin : g_ch
      logic [P_ADJ_WIDTH-1:0]   r_offset;
      logic [P_ADJ_WIDTH-1:0]   w_next;
      logic [P_ADJ_WIDTH-1:0]   w_eff;
      logic [P_PHASE_WIDTH-1:0] w_ofs_ext;
      logic                     w_hit;

      // Out-of-range channel numbers match no generate instance, so such a
      // request is acknowledged without touching any offset.
      assign w_hit = w_commit & (r_ch == C_CH_W'(ch));

      always_comb begin
         case (r_mode)
            C_MODE_SUB:  w_next = r_offset - r_val;
            C_MODE_LOAD: w_next = r_val;
            default:     w_next = r_offset + r_val;
         endcase
      end

      assign w_eff = w_hit ? w_next : r_offset;

      // Offset occupies the top P_ADJ_WIDTH bits; lower phase bits pass through.
      always_comb begin
         w_ofs_ext = '0;
         w_ofs_ext[P_PHASE_WIDTH-1 -: P_ADJ_WIDTH] = w_eff;
      end

      assign w_sum[ch*P_PHASE_WIDTH +: P_PHASE_WIDTH] =
         r_s1_phase[ch*P_PHASE_WIDTH +: P_PHASE_WIDTH] + w_ofs_ext;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            r_offset <= '0;
         end else if (w_clr) begin
            r_offset <= '0;
         end else if (w_hit) begin
            r_offset <= w_next;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Two-stage datapath; o_phase holds its last value while valid is low
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s1_phase    <= '0;
         r_s1_valid    <= 1'b0;
         o_phase       <= '0;
         o_phase_valid <= 1'b0;
      end else begin
         r_s1_phase    <= i_phase;
         r_s1_valid    <= i_phase_valid;
         o_phase_valid <= r_s1_valid;
         if (r_s1_valid) begin
            o_phase <= w_sum;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Handshake FSM. The edge detector tracks even while busy, so a request
   // held high across the ack does not retrigger.
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_req_d <= 1'b0;
         r_ch    <= '0;
         r_val   <= '0;
         r_mode  <= '0;
      end else begin
         r_req_d <= i_adj_req;
         if (w_clr) begin
            r_state <= S_IDLE;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_req_edge) begin
                     r_ch    <= i_adj_ch;
                     r_val   <= i_adj_val;
                     r_mode  <= i_adj_mode;
                     r_state <= S_ARM;
                  end
               end
               S_ARM: begin
                  if (r_s1_valid) begin
                     r_state <= S_ACK;
                  end
               end
               S_ACK:   r_state <= S_IDLE;
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_phase_adjust_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_phase_adjust_unit
// Purpose  : Self-checking bench for phase_adjust_unit. A sample-level model
//            (offset table, pending request, one-sample pipeline) predicts
//            every output after every clock.
// Revision : 1.0 - initial release
// ============================================================================
module tb_phase_adjust_unit;

   localparam int NCH = 3;
   localparam int PW  = 24;
   localparam int AW  = 12;
   localparam int CW  = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              offset_clr;
   logic              i_phase_valid;
   logic [NCH*PW-1:0] i_phase;
   logic              i_adj_req;
   logic [CW-1:0]     i_adj_ch;
   logic [AW-1:0]     i_adj_val;
   logic [1:0]        i_adj_mode;
   logic              o_phase_valid;
   logic [NCH*PW-1:0] o_phase;
   logic              o_adj_busy;
   logic              o_adj_ack;

   always #5 clk = ~clk;

   phase_adjust_unit #(.P_NUM_CH(NCH), .P_PHASE_WIDTH(PW), .P_ADJ_WIDTH(AW)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
`ifdef PHASE_ADJ_CLEAR_EN
      .i_offset_clr (offset_clr),
`endif
      .i_phase_valid(i_phase_valid),
      .i_phase      (i_phase),
      .i_adj_req    (i_adj_req),
      .i_adj_ch     (i_adj_ch),
      .i_adj_val    (i_adj_val),
      .i_adj_mode   (i_adj_mode),
      .o_phase_valid(o_phase_valid),
      .o_phase      (o_phase),
      .o_adj_busy   (o_adj_busy),
      .o_adj_ack    (o_adj_ack)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state
   int unsigned m_off [NCH];
   int unsigned m_out [NCH];
   int unsigned m_s   [NCH];
   bit          m_s_valid;
   bit          m_pending;
   int          m_pch;
   int unsigned m_pval;
   int          m_pmode;
   bit          m_req_prev;
   bit          m_ack_next;
   int          m_block;
   int          t = 0;
   int          acks;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NCH*PW-1:0] pk(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
      logic [NCH*PW-1:0] v;
      v = '0;
      v[0*PW +: PW] = PW'(a);
      v[1*PW +: PW] = PW'(b);
      v[2*PW +: PW] = PW'(c);
      return v;
   endfunction

   function automatic logic [NCH*PW-1:0] rnd_phase();
      logic [NCH*PW-1:0] v;
      for (int c = 0; c < NCH; c++) v[c*PW +: PW] = PW'($urandom);
      return v;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_off[c] = 0;
         m_out[c] = 0;
         m_s[c]   = 0;
      end
      m_s_valid  = 0;
      m_pending  = 0;
      m_req_prev = 0;
      m_ack_next = 0;
      m_block    = -10;
   endtask

   // One clock: drive at negedge, predict, then compare at the next negedge.
   task automatic step(input bit v, input logic [NCH*PW-1:0] ph, input bit req,
                       input int ch, input int unsigned val, input int mode,
                       input bit clr = 1'b0);
      bit exp_ack, exp_busy, exp_valid;
      i_phase_valid = v;
      i_phase       = ph;
      i_adj_req     = req;
      i_adj_ch      = CW'(ch);
      i_adj_val     = AW'(val);
      i_adj_mode    = 2'(mode);
      offset_clr    = clr;

      exp_ack    = m_ack_next;
      m_ack_next = 0;
      if (!clr && req && !m_req_prev && !m_pending && t > m_block) begin
         m_pending = 1;
         m_pch     = ch;
         m_pval    = val;
         m_pmode   = mode;
      end
      m_req_prev = req;
      exp_busy   = clr ? 1'b0 : m_pending;
      if (!clr && v && m_pending) begin
         if (m_pch < NCH) begin
            case (m_pmode)
               1:       m_off[m_pch] = (m_off[m_pch] - m_pval) % 4096;
               2:       m_off[m_pch] = m_pval;
               default: m_off[m_pch] = (m_off[m_pch] + m_pval) % 4096;
            endcase
         end
         m_pending  = 0;
         m_block    = t + 2;
         m_ack_next = 1;
      end
      exp_valid = m_s_valid;
      if (m_s_valid) for (int c = 0; c < NCH; c++) m_out[c] = m_s[c];
      m_s_valid = v;
      if (v) for (int c = 0; c < NCH; c++)
         m_s[c] = (int'(ph[c*PW +: PW]) + (m_off[c] << (PW-AW))) % (1 << PW);
      if (clr) begin
         for (int c = 0; c < NCH; c++) m_off[c] = 0;
         m_pending = 0;
      end

      @(posedge clk);
      @(negedge clk);
      check("valid", 32'(o_phase_valid), 32'(exp_valid));
      check("ack",   32'(o_adj_ack),     32'(exp_ack));
      check("busy",  32'(o_adj_busy),    32'(exp_busy));
      for (int c = 0; c < NCH; c++)
         check($sformatf("phase_ch%0d", c), 32'(o_phase[c*PW +: PW]), m_out[c]);
      if (o_adj_ack) acks++;
      t++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, '0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      i_adj_req     = 0;
      i_phase_valid = 0;
      #2 rst_n = 0;
      #1;
      check("rst_busy",  32'(o_adj_busy),    0);
      check("rst_ack",   32'(o_adj_ack),     0);
      check("rst_valid", 32'(o_phase_valid), 0);
      for (int c = 0; c < NCH; c++)
         check($sformatf("rst_phase_ch%0d", c), 32'(o_phase[c*PW +: PW]), 0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1;
      model_reset();
   endtask

   initial begin
      rst_n = 0; offset_clr = 0; i_phase_valid = 0; i_phase = '0;
      i_adj_req = 0; i_adj_ch = '0; i_adj_val = '0; i_adj_mode = '0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("init_valid", 32'(o_phase_valid), 0);
      check("init_busy",  32'(o_adj_busy), 0);
      check("init_ack",   32'(o_adj_ack), 0);
      check("init_phase", o_phase[31:0], 0);
      rst_n = 1;

      // Pass-through with zero offsets
      step(1, pk(24'h100000, 24'h200000, 0), 0, 0, 0, 0);
      step(0, '0, 0, 0, 0, 0);
      check("pass_valid", 32'(o_phase_valid), 1);
      check("pass_ch0", 32'(o_phase[0*PW +: PW]), 32'h100000);
      check("pass_ch1", 32'(o_phase[1*PW +: PW]), 32'h200000);
      idle(1);

      // Add 1 to ch1; first sample after the request carries it
      step(0, '0, 1, 1, 1, 0);
      check("arm_busy", 32'(o_adj_busy), 1);
      step(1, pk(24'h100000, 24'h200000, 0), 1, 1, 1, 0);
      step(0, '0, 0, 0, 0, 0);
      check("add_ch1", 32'(o_phase[1*PW +: PW]), 32'h201000);
      check("add_ch0", 32'(o_phase[0*PW +: PW]), 32'h100000);
      check("add_ack", 32'(o_adj_ack), 1);
      step(0, '0, 0, 0, 0, 0);
      check("ack_pulse", 32'(o_adj_ack), 0);
      idle(2);

      // Load 0xFFF into ch0, top-bit wrap of the sum
      step(0, '0, 1, 0, 12'hFFF, 2);
      step(1, pk(24'hFFF000, 0, 0), 0, 0, 0, 0);
      step(0, '0, 0, 0, 0, 0);
      check("wrap_ch0", 32'(o_phase[0*PW +: PW]), 32'hFFE000);
      idle(3);

      // Subtract 1 twice from ch1 (1 -> 0 -> 0xFFF)
      step(0, '0, 1, 1, 1, 1);
      step(1, '0, 0, 0, 0, 0);
      idle(3);
      step(0, '0, 1, 1, 1, 1);
      step(1, pk(0, 0, 0), 0, 0, 0, 0);
      step(0, '0, 0, 0, 0, 0);
      check("sub_wrap_ch1", 32'(o_phase[1*PW +: PW]), 32'hFFF000);
      idle(3);

      // Request held high: single ack
      acks = 0;
      for (int i = 0; i < 10; i++) step(1, rnd_phase(), 1, 2, 5, 0);
      step(0, '0, 0, 0, 0, 0);
      check("held_req_acks", 32'(acks), 1);
      idle(3);

      // Second edge while busy is ignored
      acks = 0;
      step(0, '0, 1, 0, 1, 0);
      step(0, '0, 0, 0, 0, 0);
      step(0, '0, 1, 0, 1, 0);
      step(1, rnd_phase(), 1, 0, 1, 0);
      for (int i = 0; i < 6; i++) step(0, '0, 0, 0, 0, 0);
      check("busy_edge_acks", 32'(acks), 1);

      // Out-of-range channel: ack, offsets untouched
      step(0, '0, 1, 3, 12'h123, 2);
      step(1, rnd_phase(), 0, 0, 0, 0);
      step(0, '0, 0, 0, 0, 0);
      check("badch_ack", 32'(o_adj_ack), 1);
      idle(3);

      // Reset while armed
      step(0, '0, 1, 1, 12'h055, 0);
      check("pre_rst_busy", 32'(o_adj_busy), 1);
      do_reset();
      step(1, pk(24'h100000, 24'h200000, 24'h300000), 0, 0, 0, 0);
      step(0, '0, 0, 0, 0, 0);
      check("post_rst_ch1", 32'(o_phase[1*PW +: PW]), 32'h200000);
      check("post_rst_ack", 32'(o_adj_ack), 0);

`ifdef PHASE_ADJ_CLEAR_EN
      step(0, '0, 1, 0, 12'h321, 2);
      step(1, rnd_phase(), 0, 0, 0, 0);
      idle(3);
      step(0, '0, 1, 1, 7, 2);
      step(0, '0, 0, 0, 0, 0, 1'b1);
      check("clr_busy", 32'(o_adj_busy), 0);
      acks = 0;
      idle(3);
      check("clr_no_ack", 32'(acks), 0);
      step(1, pk(24'h100000, 24'h200000, 0), 0, 0, 0, 0);
      step(0, '0, 0, 0, 0, 0);
      check("clr_ch0", 32'(o_phase[0*PW +: PW]), 32'h100000);
`endif

      // Randomized traffic
      begin
         bit req_r = 0;
         for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) req_r = ~req_r;
            step($urandom_range(0, 1) == 1, rnd_phase(), req_r,
                 $urandom_range(0, 3), $urandom_range(0, 4095), $urandom_range(0, 3));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
